// File: rtl/load_store_unit.sv
// load_store_unit
//   Sits in front of a word-wide data memory that has no byte enables and
//   turns byte-addressed CPU loads/stores (byte/half/word, signed/unsigned)
//   into whole-word accesses. Sub-word stores become read-modify-write.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    request handshake (ready only while idle)
//   req_write                1 = store, 0 = load
//   req_size                 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned             loads: zero-extend when 1, sign-extend when 0
//   req_addr                 byte address (ADDR_WIDTH+2 bits)
//   req_wdata                store data, right-justified
//   resp_valid               one-cycle response pulse
//   resp_rdata / resp_err    load result / misaligned-or-illegal flag
//   mem_read / mem_write     one-cycle memory strobes
//   address                  word address to memory
//   write_data / read_data   memory write word / memory read word
//                            (read_data valid the cycle after mem_read)
module load_store_unit #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [ADDR_WIDTH+1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDR_WIDTH-1:0]   address,
    output logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH-1:0]   read_data
);

    typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RESP} state_t;

    state_t          state_reg;
    logic            write_reg;
    logic            unsigned_reg;
    logic [1:0]      size_reg;
    logic [1:0]      lane_reg;      // byte offset within the word
    logic [31:0]     wdata_reg;

    logic            misaligned;
    logic [31:0]     merged_word;
    logic [31:0]     shifted_word;
    logic [31:0]     load_value;

    assign req_ready = (state_reg == IDLE);

    // Size 11 is folded into the misaligned case so it never reaches memory.
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Read-modify-write merge: each byte lane takes either the old memory
    // byte or the matching byte of the store data.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       lane_hit;
            logic [7:0] new_byte;
            assign lane_hit = ((size_reg == 2'b00) && (lane_reg == LANE)) ||
                              ((size_reg == 2'b01) && (lane_reg[1] == LANE[1]));
            // Halves put their low byte in the even lane, high byte in the odd one.
            assign new_byte = ((size_reg == 2'b01) && LANE[0]) ? wdata_reg[15:8]
                                                                : wdata_reg[7:0];
            assign merged_word[8*gi +: 8] = lane_hit ? new_byte : read_data[8*gi +: 8];
        end
    endgenerate

    // Load path: right-justify the addressed lane, then extend.
    always_comb begin
        shifted_word = read_data >> {lane_reg, 3'b000};
        load_value   = read_data;
        case (size_reg)
            2'b00: load_value = unsigned_reg ? {24'd0, shifted_word[7:0]}
                                             : {{24{shifted_word[7]}}, shifted_word[7:0]};
            2'b01: load_value = unsigned_reg ? {16'd0, shifted_word[15:0]}
                                             : {{16{shifted_word[15]}}, shifted_word[15:0]};
            default: load_value = read_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            write_reg    <= 1'b0;
            unsigned_reg <= 1'b0;
            size_reg     <= 2'b00;
            lane_reg     <= 2'b00;
            wdata_reg    <= 32'd0;
            resp_valid   <= 1'b0;
            resp_err     <= 1'b0;
            resp_rdata   <= 32'd0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            address      <= '0;
            write_data   <= 32'd0;
        end else begin
            // Strobes and the response are pulses; states below raise them.
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        write_reg    <= req_write;
                        unsigned_reg <= req_unsigned;
                        size_reg     <= req_size;
                        lane_reg     <= req_addr[1:0];
                        wdata_reg    <= req_wdata;
                        if (misaligned) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                            state_reg  <= RESP;
                        end else begin
                            address <= req_addr[ADDR_WIDTH+1:2];
                            if (req_write && (req_size == 2'b10)) begin
                                mem_write  <= 1'b1;
                                write_data <= req_wdata;
                                state_reg  <= WR;
                            end else begin
                                mem_read  <= 1'b1;
                                state_reg <= RD;
                            end
                        end
                    end
                end
                RD: state_reg <= RD_WAIT;
                RD_WAIT: begin
                    // read_data is valid in this cycle.
                    if (write_reg) begin
                        mem_write  <= 1'b1;
                        write_data <= merged_word;
                        state_reg  <= WR;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_rdata <= load_value;
                        state_reg  <= RESP;
                    end
                end
                WR: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= 32'd0;
                    state_reg  <= RESP;
                end
                RESP: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [9:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  address;
    logic [31:0] write_data;
    logic [31:0] read_data = '0;

    load_store_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_read(mem_read), .mem_write(mem_write), .address(address),
        .write_data(write_data), .read_data(read_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Data memory the unit talks to (registered read, one-cycle latency).
    logic [31:0] mem_arr [256];
    always @(posedge clk) begin
        if (mem_write) mem_arr[address] <= write_data;
        if (mem_read)  read_data <= mem_arr[address];
    end

    // Reference view of memory, updated when a request is issued.
    logic [31:0] ref_mem [256];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        logic [7:0]  waddr;
        logic [31:0] wdata;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];

    int n_pass = 0;
    int n_total = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int total_wr = 0;
    int total_resp = 0;
    logic prev_rd = 1'b0;
    logic prev_wr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: protocol checks every cycle, scoreboard pop on each response.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            rd_cnt  = 0;
            wr_cnt  = 0;
            prev_rd = 1'b0;
            prev_wr = 1'b0;
        end else begin
            if (mem_read || mem_write) check("strobe_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
            if (mem_read)  check("rd_one_cycle", {31'd0, prev_rd}, 32'd0);
            if (mem_write) check("wr_one_cycle", {31'd0, prev_wr}, 32'd0);
            if (mem_read) rd_cnt++;
            if (mem_write) begin
                wr_cnt++;
                total_wr++;
                if (sb.size() > 0) begin
                    check("wr_addr", {24'd0, address}, {24'd0, sb[0].waddr});
                    check("wr_data", write_data, sb[0].wdata);
                end else begin
                    check("wr_unexpected", 32'd1, 32'd0);
                end
            end
            prev_rd = mem_read;
            prev_wr = mem_write;
            if (resp_valid) begin
                total_resp++;
                if (sb.size() == 0) begin
                    check("resp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    $display("resp: rdata=%h err=%0d lat=%0d", resp_rdata, resp_err, cyc - e.acc_cyc + 1);
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                    check("resp_latency", cyc - e.acc_cyc + 1, e.lat);
                    check("mem_read_count", rd_cnt, e.nrd);
                    check("mem_write_count", wr_cnt, e.nwr);
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    task automatic wait_ready();
        int waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    // Issue one request and push the reference model's expected response.
    task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [9:0] a, input logic [31:0] wd);
        exp_t e;
        logic [7:0]  wi;
        logic [31:0] old_w, mask, v;
        int sh;
        wait_ready();
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        wi    = a[9:2];
        old_w = ref_mem[wi];
        sh    = (sz == 2'b00) ? 8 * int'(a[1:0]) : (sz == 2'b01) ? 16 * int'(a[1]) : 0;
        e.waddr = wi;
        e.wdata = 32'd0;
        if ((sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)) begin
            e.rdata = 32'd0; e.err = 1'b1; e.lat = 1; e.nrd = 0; e.nwr = 0;
        end else if (w) begin
            mask = (sz == 2'b00) ? (32'h0000_00FF << sh) :
                   (sz == 2'b01) ? (32'h0000_FFFF << sh) : 32'hFFFF_FFFF;
            ref_mem[wi] = (old_w & ~mask) | ((wd << sh) & mask);
            e.rdata = 32'd0; e.err = 1'b0;
            e.lat = (sz == 2'b10) ? 2 : 4;
            e.nrd = (sz == 2'b10) ? 0 : 1;
            e.nwr = 1;
            e.wdata = ref_mem[wi];
        end else begin
            v = old_w >> sh;
            if (sz == 2'b00) begin
                v = v & 32'hFF;
                if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end else if (sz == 2'b01) begin
                v = v & 32'hFFFF;
                if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            e.rdata = v; e.err = 1'b0; e.lat = 3; e.nrd = 1; e.nwr = 0;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        e.acc_cyc = cyc;
        sb.push_back(e);
        $display("req: w=%0d size=%0d uns=%0d addr=%h wdata=%h exp_rdata=%h exp_err=%0d",
                 w, sz, uns, a, wd, e.rdata, e.err);
    endtask

    initial begin
        int wr_before, resp_before, waited;
        logic [1:0] rsz;
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = $urandom;
            ref_mem[i] = mem_arr[i];
        end

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("reset_resp_err", {31'd0, resp_err}, 32'd0);
        check("reset_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check("reset_resp_rdata", resp_rdata, 32'd0);
        check("reset_address", {24'd0, address}, 32'd0);
        check("reset_write_data", write_data, 32'd0);

        // Directed sequence
        issue(1'b1, 2'b10, 1'b0, 10'h004, 32'hA5A5_A5A5);
        issue(1'b0, 2'b10, 1'b0, 10'h004, 32'd0);
        issue(1'b1, 2'b00, 1'b0, 10'h006, 32'h0000_005A);
        issue(1'b0, 2'b10, 1'b0, 10'h004, 32'd0);
        issue(1'b0, 2'b00, 1'b0, 10'h007, 32'd0);
        issue(1'b0, 2'b00, 1'b1, 10'h007, 32'd0);
        issue(1'b0, 2'b01, 1'b0, 10'h006, 32'd0);
        issue(1'b0, 2'b00, 1'b0, 10'h006, 32'd0);
        issue(1'b0, 2'b10, 1'b0, 10'h005, 32'd0);
        issue(1'b1, 2'b01, 1'b0, 10'h003, 32'h0000_1234);
        issue(1'b0, 2'b11, 1'b0, 10'h004, 32'd0);

        // Reset during RD_WAIT of a byte store: memory must stay untouched.
        wait_ready();
        waited = 0;
        while (sb.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("drain_before_reset", sb.size(), 32'd0);
        wr_before   = total_wr;
        resp_before = total_resp;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 10'h004; req_wdata = 32'h0000_00FF;
        @(posedge clk); #1 req_valid = 1'b0;   // accepted, now in RD
        @(posedge clk); #1 rst = 1'b1;         // now in RD_WAIT
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort_req_ready", {31'd0, req_ready}, 32'd1);
        check("abort_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        repeat (5) @(negedge clk);
        check("abort_no_write", total_wr - wr_before, 32'd0);
        check("abort_no_resp", total_resp - resp_before, 32'd0);
        issue(1'b0, 2'b10, 1'b0, 10'h004, 32'd0);

        // Randomized traffic in a small address window to force reuse.
        for (int n = 0; n < 300; n++) begin
            rsz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) rsz = 2'b11;
            else if (rsz == 2'b11) rsz = 2'b10;
            issue(1'($urandom_range(0, 1)), rsz, 1'($urandom_range(0, 1)),
                  10'($urandom_range(0, 63)), $urandom);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        waited = 0;
        while (sb.size() > 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("final_drain", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Upstream stage of the data memory. Converts byte-addressed CPU load/store requests (byte/half/word, signed/unsigned) into word-wide memory accesses on the memory's mem_read/mem_write/address/write_data/read_data interface.
- Sub-word stores are done as read-modify-write, because the memory has no byte enables.
- Uses a valid/ready request handshake and a single-cycle response pulse.

Parameters:
- ADDR_WIDTH, 8, word-address width of the data memory; the request byte address is ADDR_WIDTH+2 bits.
- DATA_WIDTH, 32, memory word width; fixed at 32 (byte-lane logic is 4 lanes).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as misaligned.
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_WIDTH+2  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  load result (extended); 0 for stores and errors.
- resp_err  out  1  misaligned or illegal-size request; valid with resp_valid.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- address  out  ADDR_WIDTH  word address = req_addr[ADDR_WIDTH+1:2].
- write_data  out  32  word to memory.
- read_data  in  32  memory read word; valid the cycle after the cycle in which mem_read was high at a clock edge.

Behaviour:
- **Reset:** state IDLE; resp_valid, resp_err, mem_read, mem_write = 0; resp_rdata, address, write_data = 0; req_ready = 1 in the first cycle after reset.
- **Request latch:** request fields are latched on the accept edge (req_valid & req_ready). Inputs are ignored outside IDLE.
- **FSM states:** IDLE, RD, RD_WAIT, WR, RESP. All memory-side outputs and response outputs are registered.
- **Misalignment:** half with addr[0]=1, word with addr[1:0]≠0, or size 11 → IDLE→RESP. resp_err=1, resp_rdata=0, no mem_read/mem_write pulse.
- **Load:** IDLE→RD (mem_read=1, address driven) → RD_WAIT (mem_read=0; capture read_data at the edge) → RESP.
  - resp_valid is high in the 3rd cycle after the accept edge.
- **Word store:** IDLE→WR (mem_write=1 for exactly one cycle, write_data=req_wdata) → RESP with resp_rdata=0.
- **Byte/half store:** IDLE→RD→RD_WAIT (merge new lane into read_data) → WR (merged word) → RESP.
- **Lanes (little-endian):**
  - byte lane k = addr[1:0], occupying bits 8k+7:8k.
  - half lane = addr[1], occupying bits 16*addr[1]+15 : 16*addr[1].
- **Load extension:** selected lane is right-justified; bit 7/15 is replicated when req_unsigned=0, zero-filled otherwise. Word loads are passed unchanged.
- **RESP:** resp_valid=1 for exactly one cycle; no response backpressure; next state IDLE. The earliest next accept is the cycle after RESP.
- **Strobe exclusivity:** mem_read and mem_write are never high in the same cycle. Each access strobe is high for exactly one cycle.
- **Address hold:** address holds the latched word address from RD/WR through RESP.
- **Reset mid-operation:** the FSM aborts to IDLE at the reset edge. Strobes are low in the next cycle and no response is emitted. Reset in RD or RD_WAIT of a sub-word store means the memory word is left unmodified.
- **Simultaneous events:** rst has priority over any accept on the same edge. req_valid held high in RESP is not accepted until IDLE.

Test Plan:
- Word store req_addr=0x04, wdata=0xA5A5A5A5 → one-cycle mem_write with address=0x01, write_data=0xA5A5A5A5; then resp_valid=1, resp_err=0, resp_rdata=0.
- Word load req_addr=0x04 → one mem_read pulse at address 0x01; resp_rdata=0xA5A5A5A5 with resp_valid in the 3rd cycle after accept.
- Byte store 0x5A at 0x06 → mem_read, then mem_write of 0xA55AA5A5 to address 0x01; a subsequent word load returns 0xA55AA5A5.
- Extension loads on word 0xA55AA5A5:
  - signed byte at 0x07 → 0xFFFFFFA5
  - unsigned byte at 0x07 → 0x000000A5
  - signed half at 0x06 → 0xFFFFA55A
  - signed byte at 0x06 → 0x0000005A
- Misaligned word load at 0x05 and half store at 0x03 → resp_err=1, resp_rdata=0, resp_valid one cycle after accept, no mem_read/mem_write activity.
- Reset asserted during RD_WAIT of a byte store of 0xFF at 0x04 → no mem_write, no resp_valid, req_ready=1 after reset; a subsequent word load of 0x04 still returns 0xA55AA5A5.
